temporal_sync_buffer: RTL and testbench

Per-sensor holding stage directly upstream of the data assembler in the temporal-alignment path. It captures the latest lidar, camera, radar and IMU samples with their timestamps and checks that all four fall inside a timestamp window around the lidar sample. Only then does it present all four samples with their valids asserted together, so the assembler's AND of the valids yields one coherent fused frame. Stale or misaligned samples are discarded, and loss is counted.

---
 rtl/temporal_sync_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_temporal_sync_buffer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/temporal_sync_buffer.sv
// Per-sensor holding stage that releases lidar/camera/radar/IMU samples only as a timestamp-aligned set.
// Optional loss statistics (drop_cnt, timeout_cnt) are built only when SYNC_STATS_EN is defined.
module temporal_sync_buffer #(
   parameter int LIDAR_W = 512,
   parameter int CAM_W   = 3072,
   parameter int RADAR_W = 128,
   parameter int IMU_W   = 64,
   parameter int TS_W    = 32,
   parameter int WINDOW  = 1000,
   parameter int TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [LIDAR_W-1:0] lidar_in_data,
   input  logic [TS_W-1:0]    lidar_in_ts,
   input  logic               lidar_in_valid,
   input  logic [CAM_W-1:0]   camera_in_data,
   input  logic [TS_W-1:0]    camera_in_ts,
   input  logic               camera_in_valid,
   input  logic [RADAR_W-1:0] radar_in_data,
   input  logic [TS_W-1:0]    radar_in_ts,
   input  logic               radar_in_valid,
   input  logic [IMU_W-1:0]   imu_in_data,
   input  logic [TS_W-1:0]    imu_in_ts,
   input  logic               imu_in_valid,
   output logic [LIDAR_W-1:0] lidar_data,
   output logic               lidar_valid,
   output logic [CAM_W-1:0]   camera_data,
   output logic               camera_valid,
   output logic [RADAR_W-1:0] radar_data,
   output logic               radar_valid,
   output logic [IMU_W-1:0]   imu_data,
   output logic               imu_valid,
   output logic [TS_W-1:0]    out_ts,
   input  logic               out_ready,
   output logic               timeout_pulse,
   output logic [15:0]        drop_cnt,
   output logic [15:0]        timeout_cnt
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic signed [TS_W-1:0] WIN = TS_W'(WINDOW);

   typedef enum logic [1:0] {COLLECT, CHECK, EMIT} state_t;

   state_t state, state_nx;

   // bit order everywhere: 0 lidar, 1 camera, 2 radar, 3 imu
   logic [3:0]       full, full_nx, strobe, write_en;
   logic [TMR_W-1:0] timer, timer_nx;
   logic             flush, in_window;
   logic [1:0]       clr_sel;

   logic [LIDAR_W-1:0] lidar_q;
   logic [CAM_W-1:0]   camera_q;
   logic [RADAR_W-1:0] radar_q;
   logic [IMU_W-1:0]   imu_q;
   logic [TS_W-1:0]    lidar_ts_q, camera_ts_q, radar_ts_q, imu_ts_q;

   logic signed [TS_W-1:0] d_cam, d_radar, d_imu, d_min;

   assign strobe = {imu_in_valid, radar_in_valid, camera_in_valid, lidar_in_valid};

   // Modular subtraction reinterpreted as signed handles timestamp wrap.
   assign d_cam   = camera_ts_q - lidar_ts_q;
   assign d_radar = radar_ts_q - lidar_ts_q;
   assign d_imu   = imu_ts_q - lidar_ts_q;

   always_comb begin
      in_window = (d_cam   <= WIN) && (d_cam   >= -WIN) &&
                  (d_radar <= WIN) && (d_radar >= -WIN) &&
                  (d_imu   <= WIN) && (d_imu   >= -WIN);
      // Strict compares keep the earlier sensor on ties, lidar (d=0) first.
      d_min   = '0;
      clr_sel = 2'd0;
      if (d_cam < d_min) begin
         d_min   = d_cam;
         clr_sel = 2'd1;
      end
      if (d_radar < d_min) begin
         d_min   = d_radar;
         clr_sel = 2'd2;
      end
      if (d_imu < d_min) begin
         d_min   = d_imu;
         clr_sel = 2'd3;
      end
   end

   always_comb begin
      state_nx = state;
      full_nx  = full;
      timer_nx = timer;
      write_en = '0;
      flush    = 1'b0;
      case (state)
         COLLECT: begin
            flush    = (timer == TMR_LAST) && !(&(full | strobe));
            write_en = strobe;
            full_nx  = (flush ? 4'b0000 : full) | strobe;
            if (&full_nx) begin
               state_nx = CHECK;
               timer_nx = '0;
            end else if (flush || (full_nx == 4'b0000)) begin
               timer_nx = '0;
            end else begin
               timer_nx = timer + 1'b1;
            end
         end
         CHECK: begin
            if (in_window) begin
               state_nx = EMIT;
            end else begin
               full_nx[clr_sel] = 1'b0;
               state_nx         = COLLECT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               full_nx  = '0;
               state_nx = COLLECT;
            end
         end
         default: begin
            full_nx  = '0;
            timer_nx = '0;
            state_nx = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
         full  <= '0;
         timer <= '0;
      end else begin
         state <= state_nx;
         full  <= full_nx;
         timer <= timer_nx;
      end
   end

   // Payload is qualified by the full bits, so it needs no reset.
   always_ff @(posedge clk) begin
      if (write_en[0]) begin
         lidar_q    <= lidar_in_data;
         lidar_ts_q <= lidar_in_ts;
      end
      if (write_en[1]) begin
         camera_q    <= camera_in_data;
         camera_ts_q <= camera_in_ts;
      end
      if (write_en[2]) begin
         radar_q    <= radar_in_data;
         radar_ts_q <= radar_in_ts;
      end
      if (write_en[3]) begin
         imu_q    <= imu_in_data;
         imu_ts_q <= imu_in_ts;
      end
   end

   assign lidar_valid   = (state == EMIT);
   assign camera_valid  = (state == EMIT);
   assign radar_valid   = (state == EMIT);
   assign imu_valid     = (state == EMIT);
   assign lidar_data    = (state == EMIT) ? lidar_q     : '0;
   assign camera_data   = (state == EMIT) ? camera_q    : '0;
   assign radar_data    = (state == EMIT) ? radar_q     : '0;
   assign imu_data      = (state == EMIT) ? imu_q       : '0;
   assign out_ts        = (state == EMIT) ? lidar_ts_q  : '0;
   assign timeout_pulse = flush;

`ifdef SYNC_STATS_EN
   function automatic logic [2:0] cnt4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   logic [2:0]  drop_inc;
   logic [16:0] drop_sum;
   logic [15:0] drop_q, tmo_q;

   always_comb begin
      drop_inc = '0;
      case (state)
         COLLECT: drop_inc = flush ? cnt4(full) : cnt4(full & strobe);
         CHECK:   drop_inc = cnt4(strobe) + (in_window ? 3'd0 : 3'd1);
         default: drop_inc = cnt4(strobe);
      endcase
   end

   assign drop_sum = {1'b0, drop_q} + {14'd0, drop_inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= '0;
         tmo_q  <= '0;
      end else begin
         drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (flush && (tmo_q != 16'hFFFF)) tmo_q <= tmo_q + 16'd1;
      end
   end

   assign drop_cnt    = drop_q;
   assign timeout_cnt = tmo_q;
`else
   assign drop_cnt    = '0;
   assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_temporal_sync_buffer.sv
// Directed bench for temporal_sync_buffer; counter expectations follow SYNC_STATS_EN.
module tb_temporal_sync_buffer;

   localparam int LIDAR_W = 512;
   localparam int CAM_W   = 3072;
   localparam int RADAR_W = 128;
   localparam int IMU_W   = 64;
   localparam int TS_W    = 32;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [LIDAR_W-1:0] lidar_in_data, lidar_data;
   logic [CAM_W-1:0]   camera_in_data, camera_data;
   logic [RADAR_W-1:0] radar_in_data, radar_data;
   logic [IMU_W-1:0]   imu_in_data, imu_data, imu_exp;
   logic [TS_W-1:0]    lidar_in_ts, camera_in_ts, radar_in_ts, imu_in_ts, out_ts;
   logic               lidar_in_valid, camera_in_valid, radar_in_valid, imu_in_valid;
   logic               lidar_valid, camera_valid, radar_valid, imu_valid;
   logic               out_ready, timeout_pulse;
   logic [15:0]        drop_cnt, timeout_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;

   temporal_sync_buffer #(
      .LIDAR_W(LIDAR_W), .CAM_W(CAM_W), .RADAR_W(RADAR_W), .IMU_W(IMU_W),
      .TS_W(TS_W), .WINDOW(1000), .TIMEOUT(4096)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .lidar_in_data(lidar_in_data), .lidar_in_ts(lidar_in_ts), .lidar_in_valid(lidar_in_valid),
      .camera_in_data(camera_in_data), .camera_in_ts(camera_in_ts), .camera_in_valid(camera_in_valid),
      .radar_in_data(radar_in_data), .radar_in_ts(radar_in_ts), .radar_in_valid(radar_in_valid),
      .imu_in_data(imu_in_data), .imu_in_ts(imu_in_ts), .imu_in_valid(imu_in_valid),
      .lidar_data(lidar_data), .lidar_valid(lidar_valid),
      .camera_data(camera_data), .camera_valid(camera_valid),
      .radar_data(radar_data), .radar_valid(radar_valid),
      .imu_data(imu_data), .imu_valid(imu_valid),
      .out_ts(out_ts), .out_ready(out_ready), .timeout_pulse(timeout_pulse),
      .drop_cnt(drop_cnt), .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] stat(input int n);
`ifdef SYNC_STATS_EN
      return 64'(n);
`else
      return 64'(n & 0);
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic strobe(input logic [3:0] m);
      lidar_in_valid  = m[0];
      camera_in_valid = m[1];
      radar_in_valid  = m[2];
      imu_in_valid    = m[3];
      step();
      lidar_in_valid  = 1'b0;
      camera_in_valid = 1'b0;
      radar_in_valid  = 1'b0;
      imu_in_valid    = 1'b0;
   endtask

   task automatic set_ts(input logic [31:0] l, input logic [31:0] c,
                         input logic [31:0] r, input logic [31:0] i);
      lidar_in_ts  = l;
      camera_in_ts = c;
      radar_in_ts  = r;
      imu_in_ts    = i;
   endtask

   task automatic set_data(input logic [31:0] seed);
      lidar_in_data  = {16{seed ^ 32'h1111_0000}};
      camera_in_data = {96{seed ^ 32'h2222_0000}};
      radar_in_data  = {4{seed ^ 32'h3333_0000}};
      imu_in_data    = {2{seed ^ 32'h4444_0000}};
   endtask

   task automatic chk_valids(input string tag, input logic v);
      chk(tag, {60'd0, lidar_valid, camera_valid, radar_valid, imu_valid}, {60'd0, {4{v}}});
   endtask

   task automatic chk_payload(input string tag);
      chk({tag, "_lidar"},  {63'd0, lidar_data  === lidar_in_data},  64'd1);
      chk({tag, "_camera"}, {63'd0, camera_data === camera_in_data}, 64'd1);
      chk({tag, "_radar"},  {63'd0, radar_data  === radar_in_data},  64'd1);
      chk({tag, "_imu"},    {63'd0, imu_data    === imu_in_data},    64'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b1;
      lidar_in_valid = 1'b0; camera_in_valid = 1'b0; radar_in_valid = 1'b0; imu_in_valid = 1'b0;
      set_ts(0, 0, 0, 0);
      set_data(32'h0);
      step();
      chk_valids("rst_valid", 1'b0);
      chk("rst_out_ts", 64'(out_ts), 64'd0);
      chk("rst_lidar_data", {63'd0, lidar_data === '0}, 64'd1);
      chk("rst_pulse", {63'd0, timeout_pulse}, 64'd0);
      chk("rst_drop", 64'(drop_cnt), 64'd0);
      chk("rst_tmo", 64'(timeout_cnt), 64'd0);
      rst_n = 1'b1;
      step();

      // aligned set, one sensor per cycle; radar d=+1000 sits on the window edge
      set_ts(100, 600, 1100, 90);
      set_data(32'hA1);
      strobe(4'b0001);
      strobe(4'b0010);
      strobe(4'b0100);
      chk_valids("al_collect", 1'b0);
      strobe(4'b1000);
      chk_valids("al_check", 1'b0);
      step();
      chk_valids("al_emit", 1'b1);
      chk("al_out_ts", 64'(out_ts), 64'd100);
      chk_payload("al_data");
      step();
      chk_valids("al_back", 1'b0);
      chk("al_out_ts0", 64'(out_ts), 64'd0);
      chk("al_drop", 64'(drop_cnt), stat(0));

      // camera out of window, all captured in one cycle: lidar (d=0) is cleared
      set_ts(100, 1200, 300, 300);
      set_data(32'hB2);
      strobe(4'b1111);
      step();
      chk_valids("mis_reject", 1'b0);
      chk("mis_drop", 64'(drop_cnt), stat(1));
      lidar_in_ts = 1150;
      strobe(4'b0001);
      step();
      chk_valids("mis_emit", 1'b1);
      chk("mis_out_ts", 64'(out_ts), 64'd1150);
      chk_payload("mis_data");
      step();

      // radar at d=-1001 is most negative and cleared; imu d=-1000 is in window
      set_ts(5000, 5000, 3999, 4000);
      set_data(32'hC3);
      strobe(4'b1111);
      step();
      chk_valids("rad_reject", 1'b0);
      chk("rad_drop", 64'(drop_cnt), stat(2));
      radar_in_ts = 4500;
      strobe(4'b0100);
      step();
      chk_valids("rad_emit", 1'b1);
      chk("rad_out_ts", 64'(out_ts), 64'd5000);
      step();

      // wrap-around: imu d=+512 across zero
      set_ts(32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF10, 32'h0000_0100);
      set_data(32'hD4);
      strobe(4'b1111);
      step();
      chk_valids("wrap_emit", 1'b1);
      chk("wrap_out_ts", 64'(out_ts), 64'hFFFF_FF00);
      chk_payload("wrap_data");
      step();
      chk("wrap_drop", 64'(drop_cnt), stat(2));

      // timeout: lone radar sample flushed in cycle 4095 after capture
      set_ts(7000, 7000, 7000, 7000);
      set_data(32'hE5);
      strobe(4'b0100);
      repeat (4093) step();
      chk("tmo_early", {63'd0, timeout_pulse}, 64'd0);
      step();
      chk("tmo_pulse", {63'd0, timeout_pulse}, 64'd1);
      step();
      chk("tmo_pulse_end", {63'd0, timeout_pulse}, 64'd0);
      chk("tmo_cnt", 64'(timeout_cnt), stat(1));
      chk("tmo_drop", 64'(drop_cnt), stat(3));
      strobe(4'b1011);
      step();
      chk_valids("tmo_slot_empty", 1'b0);
      strobe(4'b0100);
      step();
      chk_valids("tmo_refill_emit", 1'b1);
      step();

      // backpressure: 10 stalled EMIT cycles with 3 discarded imu strobes
      out_ready = 1'b0;
      set_ts(200, 200, 200, 200);
      set_data(32'hF6);
      imu_exp = imu_in_data;
      strobe(4'b1111);
      step();
      for (int i = 0; i < 10; i++) begin
         chk_valids("bp_valid", 1'b1);
         chk("bp_out_ts", 64'(out_ts), 64'd200);
         chk("bp_imu", 64'(imu_data), 64'(imu_exp));
         imu_in_valid = (i == 1) || (i == 4) || (i == 7);
         imu_in_data  = 64'(i) ^ 64'hDEAD_0000_0000_0000;
         imu_in_ts    = 32'(300 + i);
         step();
         imu_in_valid = 1'b0;
      end
      chk("bp_drop", 64'(drop_cnt), stat(6));
      out_ready = 1'b1;
      chk_valids("bp_release", 1'b1);
      step();
      chk_valids("bp_done", 1'b0);

      // asynchronous reset while in EMIT
      out_ready = 1'b0;
      set_ts(900, 900, 900, 900);
      set_data(32'h77);
      strobe(4'b1111);
      step();
      chk_valids("rs_emit", 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk_valids("rs_async_valid", 1'b0);
      chk("rs_async_drop", 64'(drop_cnt), 64'd0);
      chk("rs_async_tmo", 64'(timeout_cnt), 64'd0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      step();
      chk_valids("rs_no_reemit", 1'b0);
      strobe(4'b0111);
      step();
      chk_valids("rs_partial", 1'b0);
      strobe(4'b1000);
      step();
      chk_valids("rs_full_emit", 1'b1);
      step();
      chk_valids("rs_done", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
